// File: rtl/vcnpu_dram_responder.sv
// Read-only responder for the vcnpu_top DRAM read interface. It serves each
// request from an internal preloadable word memory. The first word arrives
// RD_LAT cycles after the ack pulse, and dram_stall throttles the stream.
module vcnpu_dram_responder #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int MEM_AW = 12,
  parameter int RD_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              dram_req,
  input  logic [ADDR_W-1:0] dram_addr,
  input  logic [LEN_W-1:0]  dram_len,
  input  logic              dram_stall,
  output logic              dram_ack,
  output logic              dram_data_valid,
  output logic [DATA_W-1:0] dram_data_in,
  input  logic              load_en,
  input  logic [MEM_AW-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  output logic              busy,
  output logic              xfer_done,
  output logic [15:0]       req_count
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ACK,
    S_LAT,
    S_STREAM,
    S_DONE
  } state_e;

  localparam logic [3:0] LAT_INIT = 4'(RD_LAT - 1);

  state_e            state_q, state_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  logic [3:0]        lat_q, lat_d;
  logic              ack_q, ack_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q;
  logic              emit;

  logic [DATA_W-1:0] mem [2**MEM_AW];

  // Only the low MEM_AW address bits index the memory.
  logic unused_addr;
  assign unused_addr = ^dram_addr;

  // Next-state logic. "emit" marks an edge that presents mem[ptr] as a valid
  // word. The word is read at the same edge where valid rises, so a write to
  // that index in the same cycle is not seen until a later read.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    rem_d   = rem_q;
    lat_d   = lat_q;
    ack_d   = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (dram_req) begin
          ptr_d   = dram_addr[MEM_AW-1:0];
          rem_d   = dram_len;
          ack_d   = 1'b1;
          cnt_d   = cnt_q + 16'd1;
          state_d = S_ACK;
        end
      end
      S_ACK: begin
        if (rem_q == '0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (RD_LAT == 1) begin
          emit    = !dram_stall;
          state_d = S_STREAM;
        end else begin
          lat_d   = LAT_INIT;
          state_d = S_LAT;
        end
      end
      S_LAT: begin
        if (!dram_stall) begin
          if (lat_q == 4'd1) begin
            emit    = 1'b1;
            state_d = S_STREAM;
          end else begin
            lat_d = lat_q - 4'd1;
          end
        end
      end
      S_STREAM: begin
        if (rem_q == '0) begin
          done_d  = 1'b1;
          state_d = S_DONE;
        end else if (!dram_stall) begin
          emit = 1'b1;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (emit) begin
      ptr_d = ptr_q + MEM_AW'(1);
      rem_d = rem_q - LEN_W'(1);
    end
    valid_d = emit;
    busy_d  = (state_d != S_IDLE);
  end

  // State, counters and registered outputs. The data register loads only on
  // an emit edge, so it holds its last value while the stream is stalled.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      rem_q   <= '0;
      lat_q   <= '0;
      ack_q   <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      rem_q   <= rem_d;
      lat_q   <= lat_d;
      ack_q   <= ack_d;
      valid_q <= valid_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
      cnt_q   <= cnt_d;
      if (emit) data_q <= mem[ptr_q];
    end
  end

  // Preload write port. Memory contents are not reset.
  always_ff @(posedge clk) begin
    if (load_en) mem[load_addr] <= load_data;
  end

  assign dram_ack        = ack_q;
  assign dram_data_valid = valid_q;
  assign dram_data_in    = data_q;
  assign busy            = busy_q;
  assign xfer_done       = done_q;
  assign req_count       = cnt_q;

endmodule

// File: tb/tb_vcnpu_dram_responder.sv
// Testbench for vcnpu_dram_responder. A table of transfers is driven, and the
// expected words are queued from a shadow copy of the preload contents.
// Hand-written sequences cover held requests and reset during a stream.
module tb_vcnpu_dram_responder;

  localparam int RD_LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        dram_req;
  logic [31:0] dram_addr;
  logic [15:0] dram_len;
  logic        dram_stall;
  logic        dram_ack;
  logic        dram_data_valid;
  logic [15:0] dram_data_in;
  logic        load_en;
  logic [11:0] load_addr;
  logic [15:0] load_data;
  logic        busy;
  logic        xfer_done;
  logic [15:0] req_count;

  vcnpu_dram_responder #(
    .DATA_W(16),
    .ADDR_W(32),
    .LEN_W (16),
    .MEM_AW(12),
    .RD_LAT(RD_LAT)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .dram_req       (dram_req),
    .dram_addr      (dram_addr),
    .dram_len       (dram_len),
    .dram_stall     (dram_stall),
    .dram_ack       (dram_ack),
    .dram_data_valid(dram_data_valid),
    .dram_data_in   (dram_data_in),
    .load_en        (load_en),
    .load_addr      (load_addr),
    .load_data      (load_data),
    .busy           (busy),
    .xfer_done      (xfer_done),
    .req_count      (req_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [31:0] addr;
    int          len;
    int          stall_after;
    int          stall_n;
    int          load_after;
    int          load_idx;
    logic [15:0] load_val;
    logic        has_exp0;
    logic [15:0] exp0;
  } vec_t;

  int          n_vec = 0;
  int          n_err = 0;
  int          exp_reqs = 0;
  logic [15:0] shadow [4096];
  logic [15:0] exp_q [$];
  vec_t        vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic load(input int idx, input logic [15:0] v);
    @(negedge clk);
    load_en   = 1'b1;
    load_addr = idx[11:0];
    load_data = v;
    @(posedge clk);
    #1;
    load_en     = 1'b0;
    shadow[idx] = v;
  endtask

  task automatic do_xfer(input vec_t v);
    int          cyc, nvalid, first_valid, last_valid, done_cyc, stall_left;
    logic [15:0] want;
    @(negedge clk);
    dram_req  = 1'b1;
    dram_addr = v.addr;
    dram_len  = v.len[15:0];
    @(posedge clk);
    #1;
    dram_req = 1'b0;
    exp_reqs++;
    chk({v.tag, " ack"}, 32'(dram_ack), 32'd1);
    chk({v.tag, " req_count"}, 32'(req_count), 32'(exp_reqs[15:0]));
    for (int k = 0; k < v.len; k++)
      exp_q.push_back(shadow[(int'(v.addr[11:0]) + k) % 4096]);
    cyc = 0; nvalid = 0; first_valid = -1; last_valid = -1; done_cyc = -1; stall_left = 0;
    while (done_cyc < 0 && cyc < v.len + 40) begin
      @(posedge clk);
      #1;
      cyc++;
      if (load_en) begin
        load_en = 1'b0;
        shadow[v.load_idx] = v.load_val;
      end
      if (dram_data_valid) begin
        if (first_valid < 0) first_valid = cyc;
        last_valid = cyc;
        if (exp_q.size() == 0) begin
          chk({v.tag, " extra word"}, 32'(nvalid + 1), 32'(v.len));
        end else begin
          want = exp_q.pop_front();
          if (nvalid == 0 && v.has_exp0) chk({v.tag, " first word"}, 32'(dram_data_in), 32'(v.exp0));
          chk({v.tag, " data"}, 32'(dram_data_in), 32'(want));
        end
        nvalid++;
        if (nvalid == v.stall_after) stall_left = v.stall_n;
        if (nvalid == v.load_after) begin
          load_en   = 1'b1;
          load_addr = v.load_idx[11:0];
          load_data = v.load_val;
        end
      end
      if (stall_left > 0) begin
        dram_stall = 1'b1;
        stall_left--;
      end else begin
        dram_stall = 1'b0;
      end
      if (xfer_done) done_cyc = cyc;
    end
    dram_stall = 1'b0;
    chk({v.tag, " word count"}, 32'(nvalid), 32'(v.len));
    if (v.len > 0) begin
      chk({v.tag, " first valid cycle"}, 32'(first_valid), 32'(RD_LAT));
      chk({v.tag, " stream span"}, 32'(last_valid - first_valid), 32'(v.len - 1 + v.stall_n));
      chk({v.tag, " done cycle"}, 32'(done_cyc), 32'(last_valid + 1));
    end else begin
      chk({v.tag, " no valid"}, 32'(first_valid), 32'(-1));
      chk({v.tag, " done cycle"}, 32'(done_cyc), 32'd1);
    end
    exp_q.delete();
    @(posedge clk);
    #1;
    chk({v.tag, " idle after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int          acks, nvalid;
    logic [15:0] want;

    vecs[0] = '{"basic",     32'h0000_0010, 4, 0, 0, 0, 0, 16'h0000, 1'b1, 16'h0030};
    vecs[1] = '{"wrap",      32'h1000_0FFE, 4, 0, 0, 0, 0, 16'h0000, 1'b1, 16'hAAAA};
    vecs[2] = '{"stall",     32'h0000_0040, 6, 2, 2, 0, 0, 16'h0000, 1'b1, 16'h00C0};
    vecs[3] = '{"zero len",  32'h0000_0080, 0, 0, 0, 0, 0, 16'h0000, 1'b0, 16'h0000};
    vecs[4] = '{"collision", 32'h0000_0004, 2, 0, 0, 1, 5, 16'hBEEF, 1'b1, 16'h000C};
    vecs[5] = '{"reread",    32'h0000_0005, 1, 0, 0, 0, 0, 16'h0000, 1'b1, 16'hBEEF};

    rst = 1'b1; dram_req = 1'b0; dram_addr = '0; dram_len = '0; dram_stall = 1'b0;
    load_en = 1'b0; load_addr = '0; load_data = '0;
    @(negedge clk);
    @(negedge clk);
    chk("reset ack", 32'(dram_ack), 32'd0);
    chk("reset valid", 32'(dram_data_valid), 32'd0);
    chk("reset data", 32'(dram_data_in), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    chk("reset done", 32'(xfer_done), 32'd0);
    chk("reset req_count", 32'(req_count), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 4096; i++) load(i, 16'(i * 3));
    load(12'hFFE, 16'hAAAA);
    load(12'hFFF, 16'hBBBB);
    load(0, 16'h1111);
    load(1, 16'h2222);

    for (int i = 0; i < 4; i++) do_xfer(vecs[i]);

    // Request held high across a whole transfer is served again from IDLE.
    @(negedge clk);
    dram_req = 1'b1; dram_addr = 32'h0000_0100; dram_len = 16'd2;
    acks = 0; nvalid = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #1;
      if (dram_ack) begin
        acks++;
        exp_reqs++;
        exp_q.push_back(shadow[12'h100]);
        exp_q.push_back(shadow[12'h101]);
      end
      if (dram_data_valid) begin
        nvalid++;
        if (exp_q.size() == 0) begin
          chk("held req extra word", 32'(nvalid), 32'd4);
        end else begin
          want = exp_q.pop_front();
          chk("held req data", 32'(dram_data_in), 32'(want));
        end
      end
      if (i == 10) dram_req = 1'b0;
    end
    chk("held req acks", 32'(acks), 32'd2);
    chk("held req words", 32'(nvalid), 32'd4);
    chk("held req req_count", 32'(req_count), 32'(exp_reqs[15:0]));
    chk("held req idle", 32'(busy), 32'd0);
    exp_q.delete();

    // Reset during the third word of an 8-word stream.
    @(negedge clk);
    dram_req = 1'b1; dram_addr = 32'h0000_0200; dram_len = 16'd8;
    @(posedge clk);
    #1;
    dram_req = 1'b0;
    nvalid = 0;
    for (int i = 0; i < 30 && nvalid < 3; i++) begin
      @(posedge clk);
      #1;
      if (dram_data_valid) nvalid++;
    end
    chk("rst mid reached 3rd word", 32'(nvalid), 32'd3);
    rst = 1'b1;
    #1;
    exp_reqs = 0;
    chk("rst mid valid", 32'(dram_data_valid), 32'd0);
    chk("rst mid data", 32'(dram_data_in), 32'd0);
    chk("rst mid busy", 32'(busy), 32'd0);
    chk("rst mid req_count", 32'(req_count), 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      chk("rst mid no done", 32'(xfer_done), 32'd0);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("post rst stays idle", 32'({busy, xfer_done, dram_data_valid}), 32'd0);
    end
    do_xfer('{"post rst", 32'h0000_0200, 2, 0, 0, 0, 0, 16'h0000, 1'b1, 16'h0600});

    do_xfer(vecs[4]);
    do_xfer(vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
